// File: rtl/sm_phase_seq_if.sv
// Bundle between the step-pulse generator side and the phase sequencer.
// The master drives the controls and reads the status; the slave is the sequencer.
interface sm_phase_seq_if #(
    parameter int SIZE = 16
);
    logic            drv_en;
    logic            step;
    logic            dir;
    logic            half_mode;
    logic            clr_pos;
    logic [3:0]      phase;
    logic [SIZE-1:0] position;
    logic            busy;
    logic            pwr_low;
    logic            step_err;

    modport master (
        output drv_en, step, dir, half_mode, clr_pos,
        input  phase, position, busy, pwr_low, step_err
    );

    modport slave (
        input  drv_en, step, dir, half_mode, clr_pos,
        output phase, position, busy, pwr_low, step_err
    );
endinterface

// File: rtl/sm_phase_seq.sv
// Stepper-motor phase sequencer: turns step/dir pulses into four coil phases,
// tracks a signed half-step position and drops into low-power hold when idle.
module sm_phase_seq #(
    parameter int SIZE        = 16,
    parameter int HOLD_CYCLES = 1000,
    parameter int DIR_SETUP   = 2
) (
    input  logic          clk,
    input  logic          rst,
    sm_phase_seq_if.slave bus
);
    localparam int IDLE_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DCNT_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP + 1) : 1;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        LOWPWR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              step_d;
    logic              dir_q;
    logic [DCNT_W-1:0] dir_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [2:0]        index;
    logic [SIZE-1:0]   position_q;
    logic              busy_q;
    logic              pwr_low_q;
    logic              step_err_q;

    logic              step_edge;
    logic              gate_ok;
    logic              setup_ok;
    logic              accept;
    logic              violation;
    logic [2:0]        inc;
    logic              idle_done;
    logic [3:0]        phase_tbl;

    // Classify the current step edge: accepted, setup violation, or ignored.
    always_comb begin
        step_edge = bus.step & ~step_d;
        gate_ok   = bus.drv_en & (state != DISABLED);
        setup_ok  = (dir_cnt == DCNT_W'(DIR_SETUP));
        accept    = step_edge & gate_ok & setup_ok;
        violation = step_edge & gate_ok & ~setup_ok;
        inc       = bus.half_mode ? 3'd1 : 3'd2;
        idle_done = (idle_cnt == IDLE_W'(HOLD_CYCLES - 1));
    end

    // Next-state logic; dropping drv_en overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            DISABLED: if (bus.drv_en) state_nxt = ACTIVE;
            ACTIVE:   if (!accept && idle_done) state_nxt = LOWPWR;
            LOWPWR:   if (accept) state_nxt = ACTIVE;
            default:  state_nxt = DISABLED;
        endcase
        if (!bus.drv_en) state_nxt = DISABLED;
    end

    // State register plus registered busy/pwr_low flags that track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DISABLED;
            busy_q    <= 1'b0;
            pwr_low_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_q    <= (state_nxt == ACTIVE);
            pwr_low_q <= (state_nxt == LOWPWR);
        end
    end

    // Step edge history and dir stability counter, running in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_d  <= 1'b0;
            dir_q   <= 1'b0;
            dir_cnt <= '0;
        end else begin
            step_d <= bus.step;
            dir_q  <= bus.dir;
            if (bus.dir != dir_q) begin
                dir_cnt <= '0;
            end else if (!setup_ok) begin
                dir_cnt <= dir_cnt + 1'b1;
            end
        end
    end

    // Idle timer: cleared while disabled or on a step, frozen once hold is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state == DISABLED || accept) begin
            idle_cnt <= '0;
        end else if (state == ACTIVE && !idle_done) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Phase index, position and sticky error; clr_pos wins over a same-cycle step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index      <= 3'd0;
            position_q <= '0;
            step_err_q <= 1'b0;
        end else begin
            if (accept) begin
                index <= bus.dir ? (index + inc) : (index - inc);
            end
            if (bus.clr_pos) begin
                position_q <= '0;
            end else if (accept) begin
                position_q <= bus.dir ? (position_q + SIZE'(inc)) : (position_q - SIZE'(inc));
            end
            if (bus.clr_pos) begin
                step_err_q <= 1'b0;
            end else if (violation) begin
                step_err_q <= 1'b1;
            end
        end
    end

    // Coil pattern lookup; coils are de-energised while disabled.
    always_comb begin
        phase_tbl = 4'b0000;
        case (index)
            3'd0: phase_tbl = 4'b1000;
            3'd1: phase_tbl = 4'b1100;
            3'd2: phase_tbl = 4'b0100;
            3'd3: phase_tbl = 4'b0110;
            3'd4: phase_tbl = 4'b0010;
            3'd5: phase_tbl = 4'b0011;
            3'd6: phase_tbl = 4'b0001;
            3'd7: phase_tbl = 4'b1001;
            default: phase_tbl = 4'b0000;
        endcase
    end

    assign bus.phase    = (state == DISABLED) ? 4'b0000 : phase_tbl;
    assign bus.position = position_q;
    assign bus.busy     = busy_q;
    assign bus.pwr_low  = pwr_low_q;
    assign bus.step_err = step_err_q;
endmodule
